// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types and miss compare for the branch resolve unit
package bpred_pkg;

    localparam int ADDR_W = 32;
    localparam int META_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc4;
        logic              p_dir;
        logic [ADDR_W-1:0] p_target;
        logic [META_W-1:0] ras_index;
    } bpr_entry_t;

    // The target only matters when the branch was actually taken.
    function automatic logic bpr_miss(input bpr_entry_t e, input logic dir,
                                      input logic [ADDR_W-1:0] target);
        return (e.p_dir != dir) | (dir & (e.p_target != target));
    endfunction

endpackage

// File: rtl/bpr_inflight_fifo.sv
// rtl/bpr_inflight_fifo.sv - in-order queue of predicted branches awaiting resolution
module bpr_inflight_fifo
    import bpred_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  bpr_entry_t push_data,
    input  logic       pop,
    input  logic       flush,
    output bpr_entry_t head,
    output logic [PW:0] count,
    output logic       full,
    output logic       empty
);

    bpr_entry_t    mem_q [DEPTH];
    bpr_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) rd_d = rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - compares resolved branches to recorded predictions,
// drives predictor update, fetch redirect and wrong-path flush
module branch_resolve_unit #(
    parameter int DEPTH  = 8,
    parameter int META_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [31:0]       f_PC4,
    input  logic              f_p_dir,
    input  logic [31:0]       f_p_target,
    input  logic [META_W-1:0] f_ras_index,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic              e_dir,
    input  logic [31:0]       e_target,
    input  logic              soin_bpredictor_stall,
    output logic              execute_bpredictor_update,
    output logic [31:0]       execute_bpredictor_PC4,
    output logic [31:0]       execute_bpredictor_target,
    output logic              execute_bpredictor_dir,
    output logic              execute_bpredictor_miss,
    output logic              execute_bpredictor_recover_ras,
    output logic [META_W-1:0] execute_bpredictor_meta,
    output logic              fetch_redirect,
    output logic [31:0]       fetch_redirect_PC,
    output logic              err_underflow
);
    import bpred_pkg::*;

    bpr_entry_t                push_data, head;
    logic [$clog2(DEPTH):0]    count;
    logic                      full, empty;
    logic                      push, pop, miss, flush, hold;

    logic              upd_q, upd_d, dir_q, dir_d, miss_q, miss_d;
    logic              redir_q, redir_d, err_q, err_d;
    logic [31:0]       pc4_q, pc4_d, tgt_q, tgt_d, redir_pc_q, redir_pc_d;
    logic [META_W-1:0] meta_q, meta_d;

    bpr_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        push_data = '{pc4: f_PC4, p_dir: f_p_dir, p_target: f_p_target, ras_index: f_ras_index};
        hold      = upd_q & soin_bpredictor_stall;
        f_ready   = ~full;
        e_ready   = (count != '0) & ~hold;
        pop       = e_valid & e_ready;
        miss      = bpr_miss(head, e_dir, e_target);
        flush     = pop & miss;
        // A mispredict makes the branch fetched this cycle wrong-path too.
        push      = f_valid & f_ready & ~flush;
    end

    always_comb begin
        upd_d      = 1'b0;
        pc4_d      = '0;
        tgt_d      = '0;
        dir_d      = 1'b0;
        miss_d     = 1'b0;
        meta_d     = '0;
        redir_d    = 1'b0;
        redir_pc_d = '0;
        err_d      = err_q | (e_valid & empty);
        if (pop) begin
            upd_d      = 1'b1;
            pc4_d      = head.pc4;
            tgt_d      = e_target;
            dir_d      = e_dir;
            miss_d     = miss;
            meta_d     = head.ras_index;
            redir_d    = miss;
            redir_pc_d = miss ? (e_dir ? e_target : head.pc4) : '0;
        end else if (hold) begin
            // Redirect is deliberately not held: fetch must see it only once.
            upd_d  = 1'b1;
            pc4_d  = pc4_q;
            tgt_d  = tgt_q;
            dir_d  = dir_q;
            miss_d = miss_q;
            meta_d = meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_q      <= 1'b0;
            pc4_q      <= '0;
            tgt_q      <= '0;
            dir_q      <= 1'b0;
            miss_q     <= 1'b0;
            meta_q     <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            upd_q      <= upd_d;
            pc4_q      <= pc4_d;
            tgt_q      <= tgt_d;
            dir_q      <= dir_d;
            miss_q     <= miss_d;
            meta_q     <= meta_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            err_q      <= err_d;
        end
    end

    assign execute_bpredictor_update      = upd_q;
    assign execute_bpredictor_PC4         = pc4_q;
    assign execute_bpredictor_target      = tgt_q;
    assign execute_bpredictor_dir         = dir_q;
    assign execute_bpredictor_miss        = miss_q;
    assign execute_bpredictor_recover_ras = miss_q;
    assign execute_bpredictor_meta        = meta_q;
    assign fetch_redirect                 = redir_q;
    assign fetch_redirect_PC              = redir_pc_q;
    assign err_underflow                  = err_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-side counterpart of the fetch branch predictor. It records each branch prediction issued by fetch in an in-order in-flight queue. When execute resolves that branch, it compares the actual outcome with the recorded prediction. It then drives the predictor update interface (execute_bpredictor_*) and the fetch redirect (fetch_redirect, fetch_redirect_PC), and on a mispredict it flushes all younger wrong-path entries.

Parameters:
DEPTH, 8, number of in-flight predicted branches; power of 2, at least 2
META_W, 4, width of the RAS index checkpoint carried as meta

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
f_valid  in  1  fetch issued a predicted branch this cycle
f_ready  out  1  queue can accept a push (count < DEPTH)
f_PC4  in  32  PC+4 of the predicted branch
f_p_dir  in  1  predicted direction (1 = taken)
f_p_target  in  32  predicted target
f_ras_index  in  META_W  RAS index before this branch
e_valid  in  1  execute resolved the oldest in-flight branch
e_ready  out  1  resolution accepted this cycle
e_dir  in  1  actual direction
e_target  in  32  actual taken target
soin_bpredictor_stall  in  1  downstream stall; hold the update outputs
execute_bpredictor_update  out  1  update valid
execute_bpredictor_PC4  out  32  PC+4 of the resolved branch
execute_bpredictor_target  out  32  actual target
execute_bpredictor_dir  out  1  actual direction
execute_bpredictor_miss  out  1  mispredict
execute_bpredictor_recover_ras  out  1  restore RAS index (equals miss)
execute_bpredictor_meta  out  META_W  recorded ras_index
fetch_redirect  out  1  one-cycle redirect pulse
fetch_redirect_PC  out  32  correct next PC
err_underflow  out  1  sticky: e_valid seen while the queue was empty

Behaviour:
- Reset:
  - Asserting reset (low) immediately clears all outputs, the queue, its pointers and err_underflow.
  - After reset, f_ready=1 and e_ready=0.
- Queue:
  - Entry = {PC4, p_dir, p_target, ras_index}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- Push:
  - A push occurs when f_valid & f_ready & ~flush.
  - When the queue is full, f_ready=0 and f_valid is ignored, even if a pop happens in the same cycle.
- Pop:
  - e_ready = (count != 0) & ~(execute_bpredictor_update & soin_bpredictor_stall).
  - A pop occurs when e_valid & e_ready.
  - Simultaneous push and pop leaves count unchanged.
- Miss:
  - miss = (p_dir != e_dir) | (e_dir & (p_target != e_target)).
  - Computed combinationally from the queue head and the e_* inputs.
- Update register, 1-cycle latency:
  - A pop in cycle N drives all execute_bpredictor_* outputs in cycle N+1.
  - update is high for exactly one cycle unless stalled.
  - target = e_target, dir = e_dir, meta = recorded ras_index, recover_ras = miss.
- Stall:
  - While update=1 and soin_bpredictor_stall=1, all update outputs hold their values and no pop occurs.
  - update drops in the first cycle with the stall low and no new pop.
- Redirect:
  - On a popping miss, fetch_redirect=1 in cycle N+1 for exactly one cycle, never repeated during a stall hold.
  - fetch_redirect_PC = e_dir ? e_target : PC4.
  - When fetch_redirect is low, fetch_redirect_PC is 0.
- Flush:
  - A popping miss in cycle N sets flush.
  - In N+1 the queue is empty (count=0, pointers equal) and the push of cycle N is dropped.
- Underflow:
  - e_valid with count=0 is ignored and sets err_underflow, which clears only on reset.

Decomposition:
- Package bpred_pkg holds:
  - ADDR_W=32 and META_W default.
  - bpr_entry_t struct {pc4, p_dir, p_target, ras_index}.
  - The miss-compare function.
- Sub-module bpr_inflight_fifo: a synchronous FIFO of bpr_entry_t with push, pop, flush, count, full and empty.
- The top level holds the compare logic, the update/stall register and the redirect pulse logic.

Test Plan:
- Reset → every output 0, f_ready=1, e_ready=0; assert reset mid-run with 3 entries queued → count=0 and outputs 0 immediately, without waiting for a clock edge.
- Push {PC4=0x104, p_dir=1, p_target=0x200}; resolve e_dir=1, e_target=0x200 → next cycle update=1, miss=0, PC4=0x104, target=0x200, fetch_redirect=0.
- Push {0x10, p_dir=1, 0x40, ras=3} plus two younger entries; resolve e_dir=0 → miss=1, recover_ras=1, meta=3, fetch_redirect=1 with PC 0x10 for one cycle, count=0 next cycle.
- Predicted not-taken {0x20, p_dir=0}; resolve taken to 0x80 → miss=1, fetch_redirect_PC=0x80. Separately, predicted taken to 0x80 but resolved taken to 0x90 → miss=1, redirect to 0x90.
- Push 8 entries → f_ready=0 and a 9th push is dropped; one pop → f_ready=1 next cycle; pointer wrap checked over 20 push/pop pairs.
- soin_bpredictor_stall=1 for 3 cycles after a missing pop → update outputs held, e_ready=0, fetch_redirect high only in the first cycle. Separately, e_valid on an empty queue → err_underflow=1 and stays set.
